// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes the PS/2 bus, deframes 11-bit frames and queues bytes in a FIFO.
// Optional macro PS2_PARITY_CHECK_EN drops frames that fail the odd-parity check.
module ps2_rx #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ren,
    output logic [15:0] data_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_PUSH
    } state_t;

    state_t state_q, state_d;

    logic ps2_clk_s1_q, ps2_clk_s1_d;
    logic ps2_clk_s2_q, ps2_clk_s2_d;
    logic ps2_clk_prev_q, ps2_clk_prev_d;
    logic ps2_data_s1_q, ps2_data_s1_d;
    logic ps2_data_s2_q, ps2_data_s2_d;

    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic fall_edge;
    logic parity_ok;
    logic push;
    logic empty;
    logic full;
    logic pop;
    logic wr_en;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^shift_q[8:0];
`else
    assign parity_ok = 1'b1;
`endif

    assign fall_edge = ps2_clk_prev_q & ~ps2_clk_s2_q;

    // Receiver: the start bit is qualified in idle, so only data/parity/stop land in shift_q.
    always_comb begin
        ps2_clk_s1_d   = ps2_clk;
        ps2_clk_s2_d   = ps2_clk_s1_q;
        ps2_clk_prev_d = ps2_clk_s2_q;
        ps2_data_s1_d  = ps2_data;
        ps2_data_s2_d  = ps2_data_s1_q;
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        to_cnt_d       = to_cnt_q;
        push           = 1'b0;

        case (state_q)
            ST_RECV: begin
                if (fall_edge) begin
                    shift_d  = {ps2_data_s2_q, shift_q[9:1]};
                    to_cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d   = ST_PUSH;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: begin
                push      = (state_q == ST_PUSH) && shift_q[9] && parity_ok;
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                if (fall_edge && !ps2_data_s2_q) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 4'd1;
                end
            end
        endcase
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = ren && !empty;
    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (!wr_en && pop) count_d = count_q - (AW + 1)'(1);
        if (push && full && !pop) ovf_d = 1'b1;
        else if (ren)             ovf_d = 1'b0;
    end

    assign data_out = {~empty, ovf_q, 6'b0, empty ? 8'h00 : mem_q[rd_ptr_q]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_data_s1_q  <= 1'b1;
            ps2_data_s2_q  <= 1'b1;
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            to_cnt_q       <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
        end else begin
            ps2_clk_s1_q   <= ps2_clk_s1_d;
            ps2_clk_s2_q   <= ps2_clk_s2_d;
            ps2_clk_prev_q <= ps2_clk_prev_d;
            ps2_data_s1_q  <= ps2_data_s1_d;
            ps2_data_s2_q  <= ps2_data_s2_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            to_cnt_q       <= to_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q[7:0];
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed scenarios plus randomized frames checked against a queue-based model.
// Honors PS2_PARITY_CHECK_EN the same way as the design.
module tb_ps2_rx;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 100;
    localparam int HALF    = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic        ren;
    logic [15:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;

    ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ren      (ren),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b);
        if (bad_par) par = ~par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    function automatic logic [15:0] exp_dout();
        if (model_q.size() == 0) return {1'b0, model_ovf, 14'h0};
        return {1'b1, model_ovf, 6'h0, model_q[0]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic model_rx(input logic [10:0] frame);
        bit valid;
        valid = (frame[0] == 1'b0) && (frame[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        if (!(^frame[9:1])) valid = 0;
`endif
        if (valid) begin
            if (model_q.size() == DEPTH) model_ovf = 1'b1;
            else model_q.push_back(frame[8:1]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = mk_frame(b, bad_par, bad_stop);
        send_bits(f, 11);
        model_rx(f);
    endtask

    task automatic do_read(input string tag);
        ren = 1'b1;
        chk(tag, data_out, exp_dout());
        @(negedge clk);
        ren = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
        model_ovf = 1'b0;
    endtask

    initial begin
        logic [10:0] stray;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ren      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_during", data_out, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_after", data_out, 16'h0000);

        send_byte(8'h1C, 0, 0);
        chk("single_rx", data_out, 16'h801C);
        do_read("single_read");
        chk("single_after", data_out, 16'h0000);

        send_byte(8'h1C, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);
        do_read("seq_read0");
        do_read("seq_read1");
        do_read("seq_read2");
        chk("seq_empty", data_out, 16'h0000);

        send_byte(8'h1C, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
        chk("bad_parity", data_out, 16'h0000);
`else
        chk("bad_parity", data_out, 16'h801C);
`endif
        while (model_q.size() != 0) do_read("parity_drain");

        send_byte(8'h1C, 0, 1);
        chk("bad_stop", data_out, 16'h0000);

        for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i), 0, 0);
        chk("overflow_head", data_out, 16'hC001);
        for (int i = 0; i < DEPTH; i++) do_read("overflow_drain");
        chk("overflow_empty", data_out, 16'h0000);
        do_read("empty_read");
        chk("empty_read_after", data_out, 16'h0000);

        send_bits(mk_frame(8'h00, 0, 0), 4);
        repeat (TIMEOUT + 50) @(negedge clk);
        send_byte(8'h29, 0, 0);
        chk("timeout_recover", data_out, 16'h8029);
        do_read("timeout_read");

        stray = 11'h7FF;
        send_bits(stray, 1);
        send_byte(8'h33, 0, 0);
        chk("stray_start", data_out, 16'h8033);
        do_read("stray_read");

        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 2) send_bits(stray, 1);
            send_byte(8'($urandom), r == 0, r == 1);
            chk("rand_rx", data_out, exp_dout());
            for (int k = 0; k < $urandom_range(0, 2); k++) do_read("rand_read");
        end
        for (int k = 0; k <= DEPTH; k++) begin
            if (model_q.size() != 0) do_read("rand_drain");
        end
        do_read("rand_final");
        chk("rand_empty", data_out, 16'h0000);

        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        chk("pre_reset_queue", data_out, 16'h8011);
        send_bits(mk_frame(8'hA5, 0, 0), 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midframe_reset", data_out, 16'h0000);
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release", data_out, 16'h0000);
        send_byte(8'h5A, 0, 0);
        chk("post_reset_rx", data_out, 16'h805A);
        do_read("post_reset_read");
        chk("post_reset_empty", data_out, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
